riscv_mc_ctrl: RTL and testbench

Multicycle control unit for the RV32I core. It sequences a shared-ALU / single-memory datapath one instruction at a time through Fetch, Decode, Execute, Memory and Writeback states. It drives all datapath selects, write enables and ALUControl, resolves all six conditional branch types from the ALU flags, and stalls on a memory-ready handshake. Unsupported opcodes lock the unit in a trap state.

---
 rtl/riscv_mc_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_riscv_mc_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mc_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared-ALU, single-memory datapath, with memory-ready stalls and an illegal-op trap.
module riscv_mc_ctrl #(
    parameter bit STALL_ON_MEM = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       V,
    input  logic       N,
    input  logic       C,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       RegWrite,
    output logic       Retire,
    output logic       Illegal,
    output logic [3:0] State
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_EXECUTEI = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_LUI      = 4'd11;
    localparam logic [3:0] S_AUIPC    = 4'd12;
    localparam logic [3:0] S_TRAP     = 4'd15;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    // Subtract only for R-type sub; immediate forms pass sub_ok=0.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7b5,
                                              input logic sub_ok);
        logic [3:0] ctl;
        case (f3)
            3'b000:  ctl = (f7b5 & sub_ok) ? ALU_SUB : ALU_ADD;
            3'b001:  ctl = ALU_SLL;
            3'b010:  ctl = ALU_SLT;
            3'b011:  ctl = ALU_SLTU;
            3'b100:  ctl = ALU_XOR;
            3'b101:  ctl = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  ctl = ALU_OR;
            3'b111:  ctl = ALU_AND;
            default: ctl = ALU_ADD;
        endcase
        return ctl;
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic n,
                                          input logic v, input logic c);
        logic taken;
        case (f3)
            3'b000:  taken = z;
            3'b001:  taken = ~z;
            3'b100:  taken = n ^ v;
            3'b101:  taken = ~(n ^ v);
            3'b110:  taken = ~c;
            3'b111:  taken = c;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic       w_mem_rdy;
    logic       w_pcwrite;
    logic       w_irwrite;
    logic       w_regwrite;
    logic       w_memwrite;

    assign w_mem_rdy = STALL_ON_MEM ? MemReady : 1'b1;

    // State register; reset returns to FETCH immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state sequencing.
    always_comb begin
        w_next_state = S_TRAP;
        case (r_state)
            S_FETCH:    w_next_state = w_mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
                    OP_RTYPE:          w_next_state = S_EXECUTER;
                    OP_ITYPE:          w_next_state = S_EXECUTEI;
                    OP_JAL:            w_next_state = S_JAL;
                    OP_BRANCH:         w_next_state = S_BRANCH;
                    OP_LUI:            w_next_state = S_LUI;
                    OP_AUIPC:          w_next_state = S_AUIPC;
                    default:           w_next_state = S_TRAP;
                endcase
            end
            S_MEMADR:   w_next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next_state = w_mem_rdy ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: w_next_state = w_mem_rdy ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: w_next_state = S_ALUWB;
            S_ALUWB:    w_next_state = S_FETCH;
            S_EXECUTEI: w_next_state = S_ALUWB;
            S_JAL:      w_next_state = S_ALUWB;
            S_BRANCH:   w_next_state = S_FETCH;
            S_LUI:      w_next_state = S_ALUWB;
            S_AUIPC:    w_next_state = S_ALUWB;
            default:    w_next_state = S_TRAP;
        endcase
    end

    // Datapath control decode from the current state.
    always_comb begin
        w_pcwrite  = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_memwrite = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ImmSrc     = 3'b000;
        ALUControl = ALU_ADD;
        Retire     = 1'b0;
        Illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                w_irwrite = w_mem_rdy;
                w_pcwrite = w_mem_rdy;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == OP_JAL) ? 3'b011 : 3'b010;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = op[5] ? 3'b001 : 3'b000;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                w_regwrite = 1'b1;
                Retire     = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                w_memwrite = 1'b1;
                Retire     = w_mem_rdy;
            end
            S_EXECUTER: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_decode(funct3, funct7b5, op[5]);
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                Retire     = 1'b1;
            end
            S_EXECUTEI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_decode(funct3, funct7b5, 1'b0);
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                w_pcwrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                Retire     = 1'b1;
                w_pcwrite  = branch_taken(funct3, Zero, N, V, C);
            end
            S_LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b100;
            end
            S_AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b100;
            end
            S_TRAP: begin
                Illegal = 1'b1;
            end
            default: begin
                Illegal = 1'b0;
            end
        endcase
    end

    // Write enables are killed combinationally so reset aborts any write at once.
    assign PCWrite  = w_pcwrite  & ~reset;
    assign IRWrite  = w_irwrite  & ~reset;
    assign RegWrite = w_regwrite & ~reset;
    assign MemWrite = w_memwrite & ~reset;
    assign State    = r_state;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Scoreboard bench for riscv_mc_ctrl: per-cycle expected control words are queued
// as each instruction is issued and compared (masked) once per cycle.
module tb_riscv_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero, V, N, C;
    logic       MemReady;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    logic       RegWrite, Retire, Illegal;
    logic [3:0] State;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [23:0] val;
        logic [23:0] mask;
        logic        mr;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t ex;

    riscv_mc_ctrl #(.STALL_ON_MEM(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .V(V), .N(N), .C(C), .MemReady(MemReady),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .RegWrite(RegWrite), .Retire(Retire), .Illegal(Illegal),
        .State(State)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] obs();
        return {State, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ImmSrc, ALUControl, RegWrite, Retire, Illegal};
    endfunction

    function automatic void put(inout logic [23:0] v, inout logic [23:0] m,
                                input int f, input int pos, input int w);
        if (f >= 0) begin
            for (int b = 0; b < w; b++) begin
                v[pos+b] = f[b];
                m[pos+b] = 1'b1;
            end
        end
    endfunction

    // Field value -1 means "don't care" for that cycle.
    function automatic exp_t mk(input string nm, input logic mr, input int st,
                                input int pcw, input int adr, input int mw, input int irw,
                                input int rs, input int sa, input int sbv, input int imm,
                                input int alu, input int rw, input int ret, input int ill);
        exp_t e;
        e.name = nm; e.mr = mr; e.val = 24'h0; e.mask = 24'h0;
        put(e.val, e.mask, st,  20, 4);
        put(e.val, e.mask, pcw, 19, 1);
        put(e.val, e.mask, adr, 18, 1);
        put(e.val, e.mask, mw,  17, 1);
        put(e.val, e.mask, irw, 16, 1);
        put(e.val, e.mask, rs,  14, 2);
        put(e.val, e.mask, sa,  12, 2);
        put(e.val, e.mask, sbv, 10, 2);
        put(e.val, e.mask, imm,  7, 3);
        put(e.val, e.mask, alu,  3, 4);
        put(e.val, e.mask, rw,   2, 1);
        put(e.val, e.mask, ret,  1, 1);
        put(e.val, e.mask, ill,  0, 1);
        return e;
    endfunction

    function automatic void push_fetch(input logic mr);
        sb.push_back(mk("fetch", mr, 0, int'(mr), 0, 0, int'(mr), 2, 0, 2, 0, 0, 0, 0, 0));
    endfunction

    function automatic void push_decode(input int imm);
        sb.push_back(mk("decode", 1'b1, 1, 0, 0, 0, 0, 0, 1, 1, imm, 0, 0, 0, 0));
    endfunction

    function automatic void push_aluwb();
        sb.push_back(mk("aluwb", 1'b1, 7, 0, 0, 0, 0, 0, -1, -1, -1, -1, 1, 1, 0));
    endfunction

    task automatic test_reset();
        reset = 1'b1; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0;
        Zero = 1'b0; V = 1'b0; N = 1'b0; C = 1'b0; MemReady = 1'b1;
        ex = mk("reset_hold", 1'b1, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        checks++;
        if ((obs() & ex.mask) !== (ex.val & ex.mask)) begin
            failures++;
            $display("FAIL %s got=%h exp=%h mask=%h", ex.name, obs(), ex.val, ex.mask);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_lw();
        op = 7'b0000011; funct3 = 3'b010;
        push_fetch(1'b0);
        push_fetch(1'b1);
        push_decode(2);
        sb.push_back(mk("lw_memadr", 1'b1, 2, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0));
        sb.push_back(mk("lw_memread", 1'b1, 3, 0, 1, 0, 0, 0, -1, -1, -1, -1, 0, 0, 0));
        sb.push_back(mk("lw_memwb", 1'b1, 4, 0, 0, 0, 0, 1, -1, -1, -1, -1, 1, 1, 0));
        while (sb.size() > 0) begin
            ex = sb.pop_front();
            MemReady = ex.mr;
            @(negedge clk);
            checks++;
            if ((obs() & ex.mask) !== (ex.val & ex.mask)) begin
                failures++;
                $display("FAIL lw/%s got=%h exp=%h mask=%h", ex.name, obs(), ex.val, ex.mask);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_stall();
        op = 7'b0100011; funct3 = 3'b010;
        push_fetch(1'b1);
        push_decode(2);
        sb.push_back(mk("sw_memadr", 1'b1, 2, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0));
        sb.push_back(mk("sw_memwrite0", 1'b0, 5, 0, 1, 1, 0, 0, -1, -1, -1, -1, 0, 0, 0));
        sb.push_back(mk("sw_memwrite1", 1'b0, 5, 0, 1, 1, 0, 0, -1, -1, -1, -1, 0, 0, 0));
        sb.push_back(mk("sw_memwrite2", 1'b1, 5, 0, 1, 1, 0, 0, -1, -1, -1, -1, 0, 1, 0));
        push_fetch(1'b0);
        while (sb.size() > 0) begin
            ex = sb.pop_front();
            MemReady = ex.mr;
            @(negedge clk);
            checks++;
            if ((obs() & ex.mask) !== (ex.val & ex.mask)) begin
                failures++;
                $display("FAIL sw/%s got=%h exp=%h mask=%h", ex.name, obs(), ex.val, ex.mask);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        logic [2:0] f3 [6] = '{3'b000, 3'b100, 3'b111, 3'b010, 3'b001, 3'b110};
        logic [3:0] fl [6] = '{4'b1000, 4'b0010, 4'b0000, 4'b1111, 4'b1000, 4'b0000}; // {Z,V,N,C}
        int         tk [6] = '{1, 1, 0, 0, 0, 1};
        op = 7'b1100011; funct7b5 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            funct3 = f3[i];
            {Zero, V, N, C} = fl[i];
            push_fetch(1'b1);
            push_decode(2);
            sb.push_back(mk("branch", 1'b1, 10, tk[i], 0, 0, 0, 0, 2, 0, -1, 1, 0, 1, 0));
            while (sb.size() > 0) begin
                ex = sb.pop_front();
                MemReady = ex.mr;
                @(negedge clk);
                checks++;
                if ((obs() & ex.mask) !== (ex.val & ex.mask)) begin
                    failures++;
                    $display("FAIL br%0d/%s got=%h exp=%h mask=%h", i, ex.name, obs(), ex.val, ex.mask);
                end
                @(posedge clk); #1;
            end
        end
        {Zero, V, N, C} = 4'b0000;
    endtask

    task automatic test_alu_decode();
        logic [6:0] ops [5] = '{7'b0110011, 7'b0010011, 7'b0010011, 7'b0110011, 7'b0110011};
        logic [2:0] f3s [5] = '{3'b000, 3'b000, 3'b101, 3'b011, 3'b101};
        logic       f7s [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        int         sts [5] = '{6, 8, 8, 6, 6};
        int         alu [5] = '{1, 0, 7, 9, 8};
        int         sbs [5] = '{0, 1, 1, 0, 0};
        int         imm [5] = '{-1, 0, 0, -1, -1};
        for (int i = 0; i < 5; i++) begin
            op = ops[i]; funct3 = f3s[i]; funct7b5 = f7s[i];
            push_fetch(1'b1);
            push_decode(2);
            sb.push_back(mk("exec", 1'b1, sts[i], 0, 0, 0, 0, -1, 2, sbs[i], imm[i], alu[i], 0, 0, 0));
            push_aluwb();
            while (sb.size() > 0) begin
                ex = sb.pop_front();
                MemReady = ex.mr;
                @(negedge clk);
                checks++;
                if ((obs() & ex.mask) !== (ex.val & ex.mask)) begin
                    failures++;
                    $display("FAIL alu%0d/%s got=%h exp=%h mask=%h", i, ex.name, obs(), ex.val, ex.mask);
                end
                @(posedge clk); #1;
            end
        end
        funct7b5 = 1'b0;
    endtask

    task automatic test_jal_upper();
        op = 7'b1101111; funct3 = 3'b000;
        push_fetch(1'b1);
        push_decode(3);
        sb.push_back(mk("jal", 1'b1, 9, 1, 0, 0, 0, 0, 1, 2, -1, 0, 0, 0, 0));
        push_aluwb();
        while (sb.size() > 0) begin
            ex = sb.pop_front();
            MemReady = ex.mr;
            @(negedge clk);
            checks++;
            if ((obs() & ex.mask) !== (ex.val & ex.mask)) begin
                failures++;
                $display("FAIL jal/%s got=%h exp=%h mask=%h", ex.name, obs(), ex.val, ex.mask);
            end
            @(posedge clk); #1;
        end
        op = 7'b0010111;
        push_fetch(1'b1);
        push_decode(2);
        sb.push_back(mk("auipc", 1'b1, 12, 0, 0, 0, 0, -1, 1, 1, 4, 0, 0, 0, 0));
        push_aluwb();
        while (sb.size() > 0) begin
            ex = sb.pop_front();
            MemReady = ex.mr;
            @(negedge clk);
            checks++;
            if ((obs() & ex.mask) !== (ex.val & ex.mask)) begin
                failures++;
                $display("FAIL auipc/%s got=%h exp=%h mask=%h", ex.name, obs(), ex.val, ex.mask);
            end
            @(posedge clk); #1;
        end
        op = 7'b0110111;
        push_fetch(1'b1);
        push_decode(2);
        sb.push_back(mk("lui", 1'b1, 11, 0, 0, 0, 0, -1, 3, 1, 4, 0, 0, 0, 0));
        push_aluwb();
        while (sb.size() > 0) begin
            ex = sb.pop_front();
            MemReady = ex.mr;
            @(negedge clk);
            checks++;
            if ((obs() & ex.mask) !== (ex.val & ex.mask)) begin
                failures++;
                $display("FAIL lui/%s got=%h exp=%h mask=%h", ex.name, obs(), ex.val, ex.mask);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_trap();
        op = 7'b0000000; funct3 = 3'b000;
        push_fetch(1'b1);
        push_decode(2);
        for (int i = 0; i < 10; i++)
            sb.push_back(mk("trap", 1'b1, 15, 0, -1, 0, 0, -1, -1, -1, -1, -1, 0, 0, 1));
        while (sb.size() > 0) begin
            ex = sb.pop_front();
            MemReady = ex.mr;
            @(negedge clk);
            checks++;
            if ((obs() & ex.mask) !== (ex.val & ex.mask)) begin
                failures++;
                $display("FAIL trap/%s got=%h exp=%h mask=%h", ex.name, obs(), ex.val, ex.mask);
            end
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        op = 7'b0100011; funct3 = 3'b010;
        push_fetch(1'b1);
        push_decode(2);
        sb.push_back(mk("rst_memadr", 1'b1, 2, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0));
        sb.push_back(mk("rst_memwrite", 1'b0, 5, 0, 1, 1, 0, 0, -1, -1, -1, -1, 0, 0, 0));
        while (sb.size() > 0) begin
            ex = sb.pop_front();
            MemReady = ex.mr;
            @(negedge clk);
            checks++;
            if ((obs() & ex.mask) !== (ex.val & ex.mask)) begin
                failures++;
                $display("FAIL rstmid/%s got=%h exp=%h mask=%h", ex.name, obs(), ex.val, ex.mask);
            end
            @(posedge clk); #1;
        end
        // Still stalled in MEMWRITE; assert reset between clock edges.
        MemReady = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({MemWrite, State} !== {1'b0, 4'd0}) begin
            failures++;
            $display("FAIL rst_async got MemWrite=%b State=%0d exp MemWrite=0 State=0", MemWrite, State);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        op = 7'b0000011;
        push_fetch(1'b1);
        push_decode(2);
        while (sb.size() > 0) begin
            ex = sb.pop_front();
            MemReady = ex.mr;
            @(negedge clk);
            checks++;
            if ((obs() & ex.mask) !== (ex.val & ex.mask)) begin
                failures++;
                $display("FAIL rstmid/%s got=%h exp=%h mask=%h", ex.name, obs(), ex.val, ex.mask);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_stall();
        test_branch();
        test_alu_decode();
        test_jal_upper();
        test_trap();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
